// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one synchronous RAM port between the 6502 bus and the
// video scanner. One access in flight at a time (IDLE -> ACCESS -> RETURN),
// video has priority but yields to a waiting CPU after VID_BURST_MAX grants.
module ram_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int RAM_DEPTH     = 49152,
    parameter int VID_BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RETURN = 2'd2;

    localparam int CNT_W = $clog2(VID_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VID_BURST_MAX);
    // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [1:0]            state_q,     state_d;
    logic                  owner_cpu_q, owner_cpu_d;
    logic                  is_wr_q,     is_wr_d;
    logic                  in_range_q,  in_range_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  ram_cs_q,    ram_cs_d;
    logic                  ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q,   ram_din_d;
    logic                  cpu_ack_q,   cpu_ack_d;
    logic                  vid_ack_q,   vid_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] vid_rdata_q, vid_rdata_d;

    logic cpu_in_range;
    logic vid_in_range;
    logic vid_wins;

    assign cpu_in_range = ({1'b0, cpu_addr} < DEPTH);
    assign vid_in_range = ({1'b0, vid_addr} < DEPTH);
    // Video loses only when the CPU is waiting and the burst limit is reached.
    assign vid_wins     = vid_req && !(cpu_req && (cnt_q == CNT_MAX));

    // Next-state logic: arbitration, RAM strobe, and result return.
    always_comb begin
        state_d     = state_q;
        owner_cpu_d = owner_cpu_q;
        is_wr_d     = is_wr_q;
        in_range_d  = in_range_q;
        cnt_d       = cnt_q;
        ram_cs_d    = ram_cs_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (vid_wins) begin
                    owner_cpu_d = 1'b0;
                    is_wr_d     = 1'b0;
                    in_range_d  = vid_in_range;
                    ram_cs_d    = vid_in_range;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = vid_addr;
                    state_d     = S_ACCESS;
                    if (!cpu_req) begin
                        cnt_d = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (cpu_req) begin
                    owner_cpu_d = 1'b1;
                    is_wr_d     = cpu_we;
                    in_range_d  = cpu_in_range;
                    ram_cs_d    = cpu_in_range;
                    ram_we_d    = cpu_we & cpu_in_range;
                    ram_addr_d  = cpu_addr;
                    ram_din_d   = cpu_wdata;
                    cnt_d       = '0;
                    state_d     = S_ACCESS;
                end else begin
                    cnt_d = '0;
                end
            end
            S_ACCESS: begin
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = S_RETURN;
            end
            S_RETURN: begin
                if (owner_cpu_q) begin
                    cpu_ack_d = 1'b1;
                    if (!is_wr_q) begin
                        cpu_rdata_d = in_range_q ? ram_dout : '1;
                    end
                end else begin
                    vid_ack_d   = 1'b1;
                    vid_rdata_d = in_range_q ? ram_dout : '1;
                end
                state_d = S_IDLE;
            end
            default: begin
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_cpu_q <= 1'b0;
            is_wr_q     <= 1'b0;
            in_range_q  <= 1'b0;
            cnt_q       <= '0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_cpu_q <= owner_cpu_d;
            is_wr_q     <= is_wr_d;
            in_range_q  <= in_range_d;
            cnt_q       <= cnt_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_ack   = vid_ack_q;
    assign vid_rdata = vid_rdata_q;
    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table-driven single accesses against a behavioural 48K RAM,
// plus hand sequences for contention ordering and reset during an access.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        vid_req = 1'b0;
    logic [15:0] vid_addr = '0;
    logic        vid_ack;
    logic [7:0]  vid_rdata;
    logic        ram_cs;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;

    int tests = 0;
    int failed = 0;
    int overlap = 0;

    ram_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .RAM_DEPTH(49152), .VID_BURST_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM: write-first not needed, read returns old data.
    logic [7:0] mem [0:49151];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (cpu_ack && vid_ack) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_cpu;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        int          exp_cs;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] cpu_model = 8'h00;
    logic [7:0] vid_model = 8'h00;

    task automatic run_vec(input int idx, input vec_t v);
        int cyc = 0;
        int cs_cnt = 0;
        bit got = 0;
        bit bad_ctl = 0;
        bit other_ack = 0;
        @(negedge clk);
        if (v.is_cpu) begin
            cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end else begin
            vid_req = 1'b1; vid_addr = v.addr;
        end
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ram_cs) begin
                cs_cnt++;
                if (ram_we !== v.we || ram_addr !== v.addr || (v.we && ram_din !== v.wdata))
                    bad_ctl = 1;
            end
            if (v.is_cpu ? cpu_ack : vid_ack) got = 1;
            if (v.is_cpu ? vid_ack : cpu_ack) other_ack = 1;
        end
        $display("[TB] vec %0d %s %s addr=%04h latency=%0d cs=%0d cpu_rdata=%02h vid_rdata=%02h",
                 idx, v.is_cpu ? "CPU" : "VID", v.we ? "W" : "R", v.addr, cyc, cs_cnt,
                 cpu_rdata, vid_rdata);
        chk($sformatf("vec%0d_latency", idx), cyc, 3);
        chk($sformatf("vec%0d_cs_cycles", idx), cs_cnt, v.exp_cs);
        chk($sformatf("vec%0d_ram_ctl", idx), {31'd0, bad_ctl}, 0);
        chk($sformatf("vec%0d_other_ack", idx), {31'd0, other_ack}, 0);
        if (v.is_cpu && !v.we) cpu_model = v.exp_rdata;
        if (!v.is_cpu) vid_model = v.exp_rdata;
        chk($sformatf("vec%0d_cpu_rdata", idx), {24'd0, cpu_rdata}, {24'd0, cpu_model});
        chk($sformatf("vec%0d_vid_rdata", idx), {24'd0, vid_rdata}, {24'd0, vid_model});
        cpu_req = 1'b0;
        vid_req = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_ack_pulse", idx), {30'd0, cpu_ack, vid_ack}, 0);
    endtask

    initial begin
        logic [7:0] order [10];
        logic [7:0] exp_order [10];
        int n;
        int cyc;
        bit bad;

        //            cpu we addr      wdata  rdata  cs
        vecs[0]  = '{1'b1, 1'b1, 16'h0400, 8'h41, 8'h00, 1};
        vecs[1]  = '{1'b1, 1'b0, 16'h0400, 8'h00, 8'h41, 1};
        vecs[2]  = '{1'b1, 1'b1, 16'h2000, 8'h55, 8'h00, 1};
        vecs[3]  = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'h55, 1};
        vecs[4]  = '{1'b1, 1'b1, 16'h0000, 8'h12, 8'h00, 1};
        vecs[5]  = '{1'b1, 1'b0, 16'hC000, 8'h00, 8'hFF, 0};
        vecs[6]  = '{1'b1, 1'b1, 16'hC000, 8'h99, 8'h00, 0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'h12, 1};
        vecs[8]  = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hFF, 0};
        vecs[9]  = '{1'b1, 1'b1, 16'hBFFF, 8'hA5, 8'h00, 1};
        vecs[10] = '{1'b1, 1'b0, 16'hBFFF, 8'h00, 8'hA5, 1};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h12, 1};

        // Reset state.
        #1;
        chk("reset_outputs", {ram_cs, ram_we, ram_addr, ram_din}, 0);
        chk("reset_acks_rdata", {cpu_ack, vid_ack, cpu_rdata, vid_rdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_cs", {31'd0, ram_cs}, 0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Contention: both held, expect four video grants per CPU grant.
        exp_order = '{"V", "V", "V", "V", "C", "V", "V", "V", "V", "C"};
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
        vid_req = 1'b1; vid_addr = 16'h2000;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack && n < 10) begin order[n] = "C"; n++; end
            if (vid_ack && n < 10) begin order[n] = "V"; n++; end
        end
        cpu_req = 1'b0;
        vid_req = 1'b0;
        chk("contention_grants", n, 10);
        for (int i = 0; i < 10; i++) begin
            $display("[TB] contention grant %0d = %s", i, (i < n) ? string'(order[i]) : "-");
            chk($sformatf("contention_order%0d", i), (i < n) ? {24'd0, order[i]} : 32'd0,
                {24'd0, exp_order[i]});
        end
        cpu_model = 8'h41;
        vid_model = 8'h55;
        chk("contention_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpu_model});
        chk("contention_vid_rdata", {24'd0, vid_rdata}, {24'd0, vid_model});
        repeat (3) @(negedge clk);

        // Reset during ACCESS of a CPU read, then re-served.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
        @(negedge clk);
        chk("rst_mid_cs_before", {31'd0, ram_cs}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {ram_cs, ram_we, ram_addr, ram_din}, 0);
        chk("rst_mid_acks_rdata", {cpu_ack, vid_ack, cpu_rdata, vid_rdata}, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || ram_cs) bad = 1;
        end
        chk("rst_mid_no_ack", {31'd0, bad}, 0);
        rst_n = 1'b1;
        cyc = 0;
        while (!cpu_ack && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        $display("[TB] post-reset CPU read latency=%0d cpu_rdata=%02h", cyc, cpu_rdata);
        chk("rst_reserve_latency", cyc, 3);
        chk("rst_reserve_rdata", {24'd0, cpu_rdata}, 32'h41);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        chk("ack_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
